rc5_key_schedule_ctrl: RTL and testbench

- Sequences the full RC5 key expansion around the existing key-mixing datapath: loads the secret key words into the L array, fills the S array with P/Q magic constants, then runs the mixer until it reports done.
- Owns the write/address side of the S and L memories and muxes them between its own load/init engine and the mixer.
- Sits between the top-level cipher control (start/done) and the mixer plus the two memories.

---
 rtl/rc5_key_schedule_ctrl.sv | 125 ++++++++++++
 tb/tb_rc5_key_schedule_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rc5_key_schedule_ctrl.sv
// RC5 key-schedule controller: streams key words into L, fills S with the P/Q
// progression, then hands both memories to the key-mixing datapath until done.
module rc5_key_schedule_ctrl #(
  parameter int W = 32,
  parameter int C = 4,
  parameter int T = 26,
  parameter logic [W-1:0] P = 32'hB7E15163,
  parameter logic [W-1:0] Q = 32'h9E3779B9,
  parameter int C_LENGTH = $clog2(C),
  parameter int T_LENGTH = $clog2(T)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [W-1:0]        iKey,
  input  logic                iKeyValid,
  output logic                oKeyReady,
  output logic                oBusy,
  output logic                oDone,
  output logic                oMixStart,
  input  logic                iMixDone,
  input  logic [T_LENGTH-1:0] iMixS_address,
  input  logic [W-1:0]        iMixS_data,
  input  logic                iMixS_we,
  input  logic [C_LENGTH-1:0] iMixL_address,
  input  logic [W-1:0]        iMixL_data,
  input  logic                iMixL_we,
  output logic [T_LENGTH-1:0] oS_address,
  output logic [W-1:0]        oS_data,
  output logic                oS_we,
  output logic [C_LENGTH-1:0] oL_address,
  output logic [W-1:0]        oL_data,
  output logic                oL_we
);

  localparam int CW = (C_LENGTH > T_LENGTH) ? C_LENGTH : T_LENGTH;
  localparam logic [CW-1:0] C_LAST = CW'(C - 1);
  localparam logic [CW-1:0] T_LAST = CW'(T - 1);

  typedef enum logic [2:0] {IDLE, LOAD_L, INIT_S, MIX, FINISH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= P;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    oKeyReady  = 1'b0;
    oBusy      = 1'b1;
    oDone      = 1'b0;
    oMixStart  = 1'b0;
    oS_address = '0;
    oS_data    = '0;
    oS_we      = 1'b0;
    oL_address = '0;
    oL_data    = '0;
    oL_we      = 1'b0;
    case (state_q)
      IDLE: begin
        oBusy = 1'b0;
        if (iStart) begin
          cnt_d   = '0;
          state_d = LOAD_L;
        end
      end
      LOAD_L: begin
        oKeyReady  = 1'b1;
        oL_we      = iKeyValid;
        oL_address = cnt_q[C_LENGTH-1:0];
        oL_data    = iKey;
        if (iKeyValid) begin
          if (cnt_q == C_LAST) begin
            cnt_d   = '0;
            acc_d   = P;
            state_d = INIT_S;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      INIT_S: begin
        oS_we      = 1'b1;
        oS_address = cnt_q[T_LENGTH-1:0];
        oS_data    = acc_q;
        acc_d      = acc_q + Q;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == T_LAST) begin
          cnt_d   = '0;
          state_d = MIX;
        end
      end
      MIX: begin
        // Mixer owns both memories; its final write rides along with iMixDone.
        oMixStart  = 1'b1;
        oS_address = iMixS_address;
        oS_data    = iMixS_data;
        oS_we      = iMixS_we;
        oL_address = iMixL_address;
        oL_data    = iMixL_data;
        oL_we      = iMixL_we;
        if (iMixDone) state_d = FINISH;
      end
      FINISH: begin
        oDone   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc5_key_schedule_ctrl.sv
// Directed bench for rc5_key_schedule_ctrl with default parameters (W=32, C=4, T=26).
module tb_rc5_key_schedule_ctrl;
  localparam int W = 32;
  localparam logic [31:0] PC = 32'hB7E15163;
  localparam logic [31:0] QC = 32'h9E3779B9;

  logic          clk = 1'b0;
  logic          rst;
  logic          iStart, iKeyValid, iMixDone;
  logic [W-1:0]  iKey;
  logic          oKeyReady, oBusy, oDone, oMixStart;
  logic [4:0]    iMixS_address, oS_address;
  logic [W-1:0]  iMixS_data, oS_data;
  logic          iMixS_we, oS_we;
  logic [1:0]    iMixL_address, oL_address;
  logic [W-1:0]  iMixL_data, oL_data;
  logic          iMixL_we, oL_we;

  int errs = 0;
  int checks = 0;

  rc5_key_schedule_ctrl dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iKey(iKey), .iKeyValid(iKeyValid),
    .oKeyReady(oKeyReady), .oBusy(oBusy), .oDone(oDone), .oMixStart(oMixStart),
    .iMixDone(iMixDone), .iMixS_address(iMixS_address), .iMixS_data(iMixS_data),
    .iMixS_we(iMixS_we), .iMixL_address(iMixL_address), .iMixL_data(iMixL_data),
    .iMixL_we(iMixL_we), .oS_address(oS_address), .oS_data(oS_data), .oS_we(oS_we),
    .oL_address(oL_address), .oL_data(oL_data), .oL_we(oL_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] acc;
  logic [6:0]  pat;
  int          n;

  initial begin
    rst = 1'b1; iStart = 0; iKeyValid = 0; iKey = '0; iMixDone = 0;
    iMixS_address = '0; iMixS_data = '0; iMixS_we = 0;
    iMixL_address = '0; iMixL_data = '0; iMixL_we = 0;
    #12;
    chk("rst_busy", oBusy, 0);
    chk("rst_ready", oKeyReady, 0);
    chk("rst_mixstart", oMixStart, 0);
    chk("rst_done", oDone, 0);
    chk("rst_swe", oS_we, 0);
    chk("rst_lwe", oL_we, 0);
    tick();
    rst = 1'b0;
    tick();

    // Straight run: keys 0..3, S fill, 12-cycle mix with a stray iStart.
    iStart = 1; iKeyValid = 1; iKey = 0;
    tick();
    iStart = 0;
    for (int i = 0; i < 4; i++) begin
      iKey = i;
      #1;
      chk("load_ready", oKeyReady, 1);
      chk("load_lwe", oL_we, 1);
      chk("load_laddr", oL_address, i);
      chk("load_ldata", oL_data, i);
      chk("load_busy", oBusy, 1);
      tick();
    end
    iKeyValid = 0;
    acc = PC;
    for (int j = 0; j < 26; j++) begin
      #1;
      chk("init_ready", oKeyReady, 0);
      chk("init_swe", oS_we, 1);
      chk("init_saddr", oS_address, j);
      chk("init_sdata", oS_data, acc);
      chk("init_mixstart", oMixStart, 0);
      if (j == 0)  chk("S0",  oS_data, 32'hB7E15163);
      if (j == 1)  chk("S1",  oS_data, 32'h5618CB1C);
      if (j == 2)  chk("S2",  oS_data, 32'hF45044D5);
      if (j == 25) chk("S25", oS_data, 32'h2B4C3474);
      acc = acc + QC;
      tick();
    end
    for (int k = 1; k <= 12; k++) begin
      iStart = (k == 3);
      if (k == 12) begin
        iMixDone = 1; iMixS_we = 1; iMixS_address = 5'd7; iMixS_data = 32'hDEADBEEF;
        iMixL_we = 1; iMixL_address = 2'd2; iMixL_data = 32'h12345678;
      end
      #1;
      chk("mix_start", oMixStart, 1);
      chk("mix_nodone", oDone, 0);
      if (k < 12) chk("mix_swe_idle", oS_we, 0);
      if (k == 12) begin
        chk("mix_swe", oS_we, 1);
        chk("mix_saddr", oS_address, 7);
        chk("mix_sdata", oS_data, 32'hDEADBEEF);
        chk("mix_lwe", oL_we, 1);
        chk("mix_laddr", oL_address, 2);
        chk("mix_ldata", oL_data, 32'h12345678);
      end
      tick();
    end
    iStart = 0; iMixDone = 0; iMixS_we = 0; iMixL_we = 0;
    #1;
    chk("fin_done", oDone, 1);
    chk("fin_mixstart", oMixStart, 0);
    chk("fin_swe", oS_we, 0);
    chk("fin_lwe", oL_we, 0);
    chk("fin_busy", oBusy, 1);
    tick();
    chk("idle_busy", oBusy, 0);
    chk("idle_done", oDone, 0);
    iMixDone = 1;
    tick();
    iMixDone = 0;
    chk("stray_mixdone_busy", oBusy, 0);
    chk("stray_mixdone_done", oDone, 0);
    chk("stray_mixdone_ready", oKeyReady, 0);
    tick();
    chk("stray_mixdone_done2", oDone, 0);

    // Gapped key stream: valid 1,0,0,1,1,0,1.
    pat = 7'b1011001;
    iStart = 1; iKeyValid = 0;
    tick();
    iStart = 0;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      iKeyValid = pat[i];
      iKey = 32'hA0 + i;
      #1;
      chk("gap_ready", oKeyReady, 1);
      chk("gap_lwe", oL_we, pat[i]);
      if (pat[i]) begin
        chk("gap_laddr", oL_address, n);
        chk("gap_ldata", oL_data, 32'hA0 + i);
        n++;
      end
      tick();
    end
    iKeyValid = 0;
    #1;
    chk("gap_to_init_ready", oKeyReady, 0);
    chk("gap_to_init_swe", oS_we, 1);
    chk("gap_to_init_saddr", oS_address, 0);
    for (int j = 0; j < 11; j++) tick();
    chk("pre_rst_saddr", oS_address, 11);

    // Asynchronous reset mid-INIT_S, then restart.
    rst = 1;
    #1;
    chk("arst_swe", oS_we, 0);
    chk("arst_busy", oBusy, 0);
    chk("arst_saddr", oS_address, 0);
    #2;
    rst = 0;
    tick();
    chk("post_rst_busy", oBusy, 0);
    iStart = 1; iKeyValid = 1; iKey = 32'h55;
    tick();
    iStart = 0;
    #1;
    chk("restart_lwe", oL_we, 1);
    chk("restart_laddr", oL_address, 0);
    chk("restart_ldata", oL_data, 32'h55);
    for (int i = 0; i < 4; i++) tick();
    iKeyValid = 0;
    chk("restart_S0_addr", oS_address, 0);
    chk("restart_S0", oS_data, 32'hB7E15163);
    for (int j = 0; j < 26; j++) tick();
    iMixDone = 1;
    #1;
    chk("restart_mix", oMixStart, 1);
    tick();
    iMixDone = 0;
    chk("restart_done", oDone, 1);
    tick();
    chk("restart_idle", oBusy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
